// File: rtl/pid_pkg.sv
// Shared definitions for the balance-loop PID controller.
//   - default parameter values for pid_ctrl_param and pid_integrator
//   - aw_mode_e: anti-windup strategy selector
//   - sat_signed(): clamp a signed value into a signed field of given width
package pid_pkg;

  localparam int ERR_W_DEF   = 10;
  localparam int P_COEFF_DEF = 9;
  localparam int INTEG_W_DEF = 18;
  localparam int I_SHIFT_DEF = 6;
  localparam int D_SHIFT_DEF = 6;
  localparam int OUT_W_DEF   = 12;
  localparam int SS_W_DEF    = 27;
  localparam int AW_MODE_DEF = 0;

  typedef enum logic {
    AW_SAT    = 1'b0,  // integrator clamps at its signed limits
    AW_FREEZE = 1'b1   // integrator holds instead of winding further
  } aw_mode_e;

  // Result stays 32 bits wide; callers size-cast it down to 'width'.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v)      return max_v;
    else if (value < min_v) return min_v;
    else                    return value;
  endfunction

endpackage

// File: rtl/pid_integrator.sv
// Integrator of the balance-loop PID with selectable anti-windup.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   vld           add err into the accumulator on this edge
//   rider_off     clear the accumulator (wins over vld)
//   err           saturated pitch error, signed ERR_W
//   out_sat_pos   controller output is at its positive limit this cycle
//   out_sat_neg   controller output is at its negative limit this cycle
//   integ         accumulator, signed INTEG_W
//   i_sat         accumulator sits at its signed max or min
module pid_integrator
  import pid_pkg::*;
#(
  parameter int ERR_W   = ERR_W_DEF,
  parameter int INTEG_W = INTEG_W_DEF,
  parameter int AW_MODE = AW_MODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               rider_off,
  input  logic [ERR_W-1:0]   err,
  input  logic               out_sat_pos,
  input  logic               out_sat_neg,
  output logic [INTEG_W-1:0] integ,
  output logic               i_sat
);

  localparam logic [INTEG_W-1:0] INTEG_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
  localparam logic [INTEG_W-1:0] INTEG_MIN = {1'b1, {(INTEG_W-1){1'b0}}};

  logic [INTEG_W:0]   sum_wide;
  logic               ovf_pos;
  logic               ovf_neg;
  logic               err_pos;
  logic               err_neg;
  logic               integ_pos;
  logic               reduces;
  logic               freeze;
  logic [INTEG_W-1:0] integ_next;

  // One guard bit is enough: adding an ERR_W value to an INTEG_W value
  // can overflow by at most one bit.
  assign sum_wide  = {integ[INTEG_W-1], integ} + (INTEG_W+1)'($signed(err));
  assign ovf_pos   = (sum_wide[INTEG_W:INTEG_W-1] == 2'b01);
  assign ovf_neg   = (sum_wide[INTEG_W:INTEG_W-1] == 2'b10);

  assign err_pos   = !err[ERR_W-1] && (err != '0);
  assign err_neg   = err[ERR_W-1];
  assign integ_pos = !integ[INTEG_W-1] && (integ != '0);

  // An error opposing the accumulated sign pulls it toward zero, so it is
  // never blocked by the freeze rule.
  assign reduces = (err_pos && integ[INTEG_W-1]) || (err_neg && integ_pos);
  assign freeze  = !reduces &&
                   (ovf_pos || ovf_neg ||
                    (out_sat_pos && err_pos) || (out_sat_neg && err_neg));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    integ_next = integ;
    if (AW_MODE == int'(AW_FREEZE)) begin
      if (!freeze) integ_next = sum_wide[INTEG_W-1:0];
    end else begin
      if (ovf_pos)      integ_next = INTEG_MAX;
      else if (ovf_neg) integ_next = INTEG_MIN;
      else              integ_next = sum_wide[INTEG_W-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst)            integ <= '0;
    else if (rider_off) integ <= '0;
    else if (vld)       integ <= integ_next;
  end

  assign i_sat = (integ == INTEG_MAX) || (integ == INTEG_MIN);

endmodule

// File: rtl/pid_ctrl_param.sv
// Parametrised PID controller for the balance loop, plus soft-start timer.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   vld         new inertial sample; one integration step
//   ptch        signed pitch error (16 bit)
//   ptch_rt     signed pitch rate (16 bit)
//   pwr_up      run the soft-start counter; low clears it
//   rider_off   clear the integrator
//   PID_cntrl   registered, saturated signed control output (OUT_W)
//   cntrl_vld   registered copy of vld, aligned with PID_cntrl
//   ss_tmr      top 8 bits of the soft-start counter
//   i_sat       integrator at its signed limit
module pid_ctrl_param
  import pid_pkg::*;
#(
  parameter int ERR_W   = ERR_W_DEF,
  parameter int P_COEFF = P_COEFF_DEF,
  parameter int INTEG_W = INTEG_W_DEF,
  parameter int I_SHIFT = I_SHIFT_DEF,
  parameter int D_SHIFT = D_SHIFT_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SS_W    = SS_W_DEF,
  parameter int AW_MODE = AW_MODE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [15:0]      ptch,
  input  logic [15:0]      ptch_rt,
  input  logic             pwr_up,
  input  logic             rider_off,
  output logic [OUT_W-1:0] PID_cntrl,
  output logic             cntrl_vld,
  output logic [7:0]       ss_tmr,
  output logic             i_sat
);

  localparam int               P_W     = ERR_W + 5;
  localparam int               SUM_W   = ERR_W + 6;
  localparam logic [4:0]       P_C5    = P_COEFF[4:0];
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [31:0]      err_sat;
  logic [ERR_W-1:0]        err;
  logic signed [P_W-1:0]   err_x;
  logic signed [P_W-1:0]   coeff_x;
  logic signed [P_W-1:0]   p_term;
  logic [INTEG_W-1:0]      integ;
  logic signed [INTEG_W-1:0] i_term;
  logic signed [15:0]      d_shifted;
  logic signed [15:0]      d_term;
  logic signed [SUM_W-1:0] sum;
  logic signed [31:0]      sum_sat;
  logic [OUT_W-1:0]        out_next;
  logic                    out_sat_pos;
  logic                    out_sat_neg;
  logic [SS_W-1:0]         ss_cnt;

  always_comb begin
    err_sat   = sat_signed(32'($signed(ptch)), ERR_W);
    err       = ERR_W'(err_sat);
    err_x     = P_W'($signed(err));
    coeff_x   = P_W'($signed({1'b0, P_C5}));
    p_term    = err_x * coeff_x;
    // I_term comes from the pre-update accumulator.
    i_term    = $signed(integ) >>> I_SHIFT;
    d_shifted = $signed(ptch_rt) >>> D_SHIFT;
    d_term    = -d_shifted;
    sum       = SUM_W'(p_term) + SUM_W'(i_term) + SUM_W'(d_term);
    sum_sat   = sat_signed(32'(sum), OUT_W);
    out_next  = OUT_W'(sum_sat);
  end

  // Saturation of the value being registered this edge steers the freeze
  // rule, so the integrator stops on the same edge the output pins.
  assign out_sat_pos = (out_next == OUT_MAX);
  assign out_sat_neg = (out_next == OUT_MIN);

  pid_integrator #(
    .ERR_W  (ERR_W),
    .INTEG_W(INTEG_W),
    .AW_MODE(AW_MODE)
  ) u_integ (
    .clk        (clk),
    .rst        (rst),
    .vld        (vld),
    .rider_off  (rider_off),
    .err        (err),
    .out_sat_pos(out_sat_pos),
    .out_sat_neg(out_sat_neg),
    .integ      (integ),
    .i_sat      (i_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      PID_cntrl <= '0;
      cntrl_vld <= 1'b0;
    end else begin
      PID_cntrl <= out_next;
      cntrl_vld <= vld;
    end
  end

  // Soft-start counter holds at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst || !pwr_up)  ss_cnt <= '0;
    else if (~&ss_cnt)   ss_cnt <= ss_cnt + 1'b1;
  end

  assign ss_tmr = ss_cnt[SS_W-1 -: 8];

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Directed bench for pid_ctrl_param. Two instances share stimulus: one with
// the saturating integrator, one with the freezing integrator. A short
// soft-start counter keeps the ramp test brief.
module tb_pid_ctrl_param;

  localparam int SS_W_TB = 12;  // ss_tmr steps every 2^(12-8) = 16 cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;
  logic        pwr_up;
  logic        rider_off;

  logic [11:0] pid_cntrl;
  logic        cntrl_vld;
  logic [7:0]  ss_tmr;
  logic        i_sat;

  logic [11:0] frz_cntrl;
  logic        frz_vld;
  logic [7:0]  frz_ss;
  logic        frz_i_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pid_ctrl_param #(.SS_W(SS_W_TB), .AW_MODE(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .ptch     (ptch),
    .ptch_rt  (ptch_rt),
    .pwr_up   (pwr_up),
    .rider_off(rider_off),
    .PID_cntrl(pid_cntrl),
    .cntrl_vld(cntrl_vld),
    .ss_tmr   (ss_tmr),
    .i_sat    (i_sat)
  );

  pid_ctrl_param #(.SS_W(SS_W_TB), .AW_MODE(1)) dut_frz (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .ptch     (ptch),
    .ptch_rt  (ptch_rt),
    .pwr_up   (pwr_up),
    .rider_off(rider_off),
    .PID_cntrl(frz_cntrl),
    .cntrl_vld(frz_vld),
    .ss_tmr   (frz_ss),
    .i_sat    (frz_i_sat)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; vld = 1'b0; ptch = '0; ptch_rt = '0; pwr_up = 1'b0; rider_off = 1'b0;
    step(2);
    check("rst_cntrl", 32'(pid_cntrl), 32'h000);
    check("rst_vld",   32'(cntrl_vld), 32'h0);
    check("rst_ss",    32'(ss_tmr),    32'h00);
    check("rst_isat",  32'(i_sat),     32'h0);

    // P only: 2 * 9 = 18
    rst = 1'b0; rider_off = 1'b1;
    step(1); check("zero",   32'(pid_cntrl), 32'h000);
    ptch = 16'h0002;
    step(1); check("p_only", 32'(pid_cntrl), 32'h012);
    // D = -(0x100 >>> 6) = -4 -> 14
    ptch_rt = 16'h0100;
    step(1); check("d_term", 32'(pid_cntrl), 32'h00E);

    // Integration: P = 127*9 = 1143, D = -4, I uses pre-update integ.
    rider_off = 1'b0; vld = 1'b1; ptch = 16'h007F;
    step(1); check("int_c0",  32'(pid_cntrl), 32'h473);  // integ 0
             check("int_vld", 32'(cntrl_vld), 32'h1);
    step(1); check("int_c1",  32'(pid_cntrl), 32'h474);  // integ 127 -> I 1
    step(1); check("int_c2",  32'(pid_cntrl), 32'h476);  // integ 254 -> I 3
    vld = 1'b0;
    step(1); check("int_c3",  32'(pid_cntrl), 32'h478);  // integ 381 -> I 5
             check("vld_low", 32'(cntrl_vld), 32'h0);

    // Output saturation (integ cleared by rider_off from the first edge on).
    rider_off = 1'b1; ptch_rt = 16'h0000; ptch = 16'h00FF;
    step(1); check("sat_pos",  32'(pid_cntrl), 32'h7FF);
    ptch = 16'hFF00;
    step(1); check("sat_neg",  32'(pid_cntrl), 32'h800);  // -2304
    ptch = 16'h7000;
    step(1); check("sat_clip", 32'(pid_cntrl), 32'h7FF);  // err 511 -> 4599
    ptch = 16'h8000;
    step(1); check("sat_clipn", 32'(pid_cntrl), 32'h800); // err -512
    // Exactly at the limit: 227*9 = 2043, D = +4 -> 2047
    ptch = 16'd227; ptch_rt = 16'hFF00;
    step(1); check("edge_max", 32'(pid_cntrl), 32'h7FF);
    ptch = 16'd226;
    step(1); check("edge_below", 32'(pid_cntrl), 32'h7F6); // 2034 + 4

    // rider_off beats vld: load 128, then clear while vld stays high.
    rider_off = 1'b0; vld = 1'b1; ptch = 16'h0040; ptch_rt = 16'h0000;
    step(2);
    rider_off = 1'b1;
    step(1); check("rider_pre",  32'(pid_cntrl), 32'h242);  // 576 + 2
    vld = 1'b0; ptch = 16'h0000;
    step(1); check("rider_wins", 32'(pid_cntrl), 32'h000);
             check("rider_frz",  32'(frz_cntrl), 32'h000);

    // Anti-windup: P = 567, D = -4.
    rider_off = 1'b0; vld = 1'b1; ptch = 16'h003F; ptch_rt = 16'h0100;
    step(5000);
    check("aw0_isat", 32'(i_sat),     32'h1);
    check("aw0_out",  32'(pid_cntrl), 32'h7FF);
    check("aw1_isat", 32'(frz_i_sat), 32'h0);
    check("aw1_out",  32'(frz_cntrl), 32'h7FF);
    ptch = 16'h0000;
    // Saturating: integ 131071 -> I 2047. Freezing: integ stops at
    // 63*1508 = 95004 -> I 1484.
    step(1); check("aw0_rel", 32'(pid_cntrl), 32'h7FB);
             check("aw1_rel", 32'(frz_cntrl), 32'h5C8);
    step(1); check("aw1_hold", 32'(frz_cntrl), 32'h5C8);
             check("aw0_hold", 32'(i_sat),     32'h1);

    // Soft start.
    vld = 1'b0;
    check("ss_off", 32'(ss_tmr), 32'h00);
    pwr_up = 1'b1;
    step(15); check("ss_pre",   32'(ss_tmr), 32'h00);
    step(1);  check("ss_first", 32'(ss_tmr), 32'h01);
    step(4096); check("ss_full",  32'(ss_tmr), 32'hFF);
    step(20);   check("ss_nowrap", 32'(ss_tmr), 32'hFF);
    pwr_up = 1'b0;
    step(1);  check("ss_clear", 32'(ss_tmr), 32'h00);
    pwr_up = 1'b1;
    step(40); check("ss_mid",   32'(ss_tmr), 32'h02);

    // Reset mid-operation with everything active; integ is still at max.
    rst = 1'b1; vld = 1'b1; ptch = 16'h7000;
    step(1);
    check("mrst_cntrl", 32'(pid_cntrl), 32'h000);
    check("mrst_vld",   32'(cntrl_vld), 32'h0);
    check("mrst_ss",    32'(ss_tmr),    32'h00);
    check("mrst_isat",  32'(i_sat),     32'h0);
    rst = 1'b0; vld = 1'b0; ptch = 16'h0000; ptch_rt = 16'h0000; pwr_up = 1'b0;
    step(1);
    check("post_rst",     32'(pid_cntrl), 32'h000);
    check("post_rst_frz", 32'(frz_cntrl), 32'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_ctrl_param.md
# pid_ctrl_param

Parametrised PID controller for the balance loop: converts pitch error and pitch rate into a saturated, signed motor-drive command and produces the soft-start timer that the motor-drive stage uses to ramp authority after power-up. It is the successor to the fixed-width PID block. It adds configurable widths, coefficients and shifts, a selectable anti-windup mode, a registered output with a valid strobe, and an integrator-saturation status flag. It sits between the inertial interface (ptch, ptch_rt, vld) and the balance/steer mixing stage.

## Interface
- ERR_W, 10: width to which ptch is saturated before use.
- P_COEFF, 9: unsigned proportional coefficient (5 bits).
- INTEG_W, 18: integrator accumulator width.
- I_SHIFT, 6: arithmetic right shift from integrator to I_term.
- D_SHIFT, 6: arithmetic right shift of ptch_rt forming D_term.
- OUT_W, 12: PID_cntrl width.
- SS_W, 27: soft-start counter width; ss_tmr is its top 8 bits.
- AW_MODE, 0: 0 = saturating integrator; 1 = conditional integration (freeze).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- vld  in  1  new inertial sample; enables one integration step
- ptch  in  16  signed pitch error
- ptch_rt  in  16  signed pitch rate
- pwr_up  in  1  enables soft-start counter
- rider_off  in  1  clears integrator
- PID_cntrl  out  OUT_W  signed, saturated control output (registered)
- cntrl_vld  out  1  registered copy of vld, aligned with PID_cntrl
- ss_tmr  out  8  soft-start timer, counter[SS_W-1:SS_W-8]
- i_sat  out  1  integrator is at its positive or negative limit

## Operation
- err = ptch saturated to signed ERR_W.
- P_term = err * P_COEFF, signed, width ERR_W+5.
- I_term = integ >>> I_SHIFT.
- D_term = -(ptch_rt >>> D_SHIFT).
- sum = sign-extended P+I+D at ERR_W+6 bits; saturate to signed OUT_W (0x7FF / 0x800 at defaults).
- Integrator update, per clk, with priority rst > rider_off > vld:
  - rider_off: integ <= 0.
  - vld: integ <= integ + sext(err).
  - AW_MODE=0: an overflowing sum clamps to the signed INTEG_W max/min.
  - AW_MODE=1: the update is skipped when it would overflow, or when the output is saturated in the same sign as err. Updates that reduce the magnitude are always taken.
- i_sat = 1 while integ equals the signed INTEG_W max or min.
- Soft start: counter increments each cycle while pwr_up=1 and saturates at all-ones (no wrap). pwr_up=0 clears it to 0 on the next edge.

## Timing
- Reset values: PID_cntrl=0, cntrl_vld=0, integ=0, ss counter=0, i_sat=0.
- PID_cntrl latency is 1 cycle. Inputs sampled at edge N are visible after edge N.
- The I_term used at edge N is the pre-update integrator value. Integration takes effect in the output one cycle later.
- cntrl_vld is high for exactly the cycle following each sampled vld.
- rider_off and vld asserted together: rider_off wins; the integrator goes to 0 with no add.
- rst mid-operation clears all state on that edge, regardless of other inputs.
- ss_tmr first reads 0x01 exactly 2^(SS_W-8) cycles after pwr_up rises.

## Structure
- Package pid_pkg holds:
  - default parameter constants;
  - a function sat_signed(value, width);
  - the AW_MODE enumeration (AW_SAT, AW_FREEZE).
- One sub-module, pid_integrator: accumulator, rider_off clear, both anti-windup modes, i_sat. The top-level feeds it err, vld, rider_off and an out_sat_pos/out_sat_neg feedback.
- The top level holds the P/D arithmetic, the sum saturation, the output register and the soft-start counter.

## Test plan
- Zero/P only: ptch=0, then ptch=0x0002, ptch_rt=0, rider_off=1 → PID_cntrl=0x000, then 0x012 one cycle later.
- D term: ptch=0x0002, ptch_rt=0x0100 → PID_cntrl=0x00E (D=-4).
- Integration: rider_off=0, vld=1, ptch=0x007F, ptch_rt=0x0100 for 3 cycles → PID_cntrl in 0x476–0x47A (I_term 5).
- Output saturation: ptch=0x00FF → 0x7FF; ptch=0xFF00 → 0x800; ptch=0x7000 (clipped to err=0x1FF) → 0x7FF.
- Anti-windup:
  - AW_MODE=0: ptch=0x003F for 5000 cycles → i_sat=1, then ptch=0 gives 0x7FB–0x7FC.
  - AW_MODE=1: same stimulus → i_sat=0 and integrator frozen once output=0x7FF.
  - rider_off=1 with vld=1 → integrator 0 on the next edge.
- Soft start: pwr_up=0 for 550000 cycles → ss_tmr=0x00; pwr_up=1 for 540000 cycles → 0x01; pwr_up=0 → 0x00 next cycle; rst mid-count → all outputs 0.
